// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_ctrl
//  Purpose  : Password-check controller placed after SWITCH_IO. A rising
//             edge of the confirm key with a full digit code starts a
//             one-cycle compare against the stored password. The result
//             drives a timed unlock, a timed error indication or, after
//             MAX_TRY consecutive failures, a timed lockout. A one-cycle
//             clr_req pulse clears SWITCH_IO for the next entry.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1   system clock
//    rst_n     in   1   synchronous active-low reset
//    code      in  16   assembled digit code (4 bits per digit)
//    code_bit  in   3   number of digits entered
//    enter     in   1   confirm key (debounced, synchronous level)
//    clr_req   out  1   one-cycle clear pulse to SWITCH_IO
//    unlock    out  1   high while OPEN
//    err       out  1   high while FAIL
//    alarm     out  1   high while LOCKOUT
//    fail_cnt  out  2   consecutive failure count (saturates at MAX_TRY)
//    state     out  3   current state: IDLE=0 CHECK=1 OPEN=2 FAIL=3 LOCKOUT=4
// ----------------------------------------------------------------------------
//  Build option
//    CODE_LOCK_CHANGE_EN : when defined, a full code confirmed while OPEN
//                          becomes the new password. When undefined the
//                          password is fixed at PASS_INIT.
// ============================================================================
module code_lock_ctrl #(
  parameter int          BYTE       = 4,
  parameter logic [15:0] PASS_INIT  = 16'h1234,
  parameter int          MAX_TRY    = 3,
  parameter logic [31:0] UNLOCK_CYC = 32'd50_000_000,
  parameter logic [31:0] FAIL_CYC   = 32'd25_000_000,
  parameter logic [31:0] LOCK_CYC   = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] code,
  input  logic [2:0]  code_bit,
  input  logic        enter,
  output logic        clr_req,
  output logic        unlock,
  output logic        err,
  output logic        alarm,
  output logic [1:0]  fail_cnt,
  output logic [2:0]  state
);

  localparam int W = 4 * BYTE;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_FAIL    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  localparam logic [2:0] FULL_BITS = 3'(BYTE);
  localparam logic [1:0] MAX_TRY_V = 2'(MAX_TRY);

  // Timer reload values: the counter runs target-1 .. 0, so the state lasts
  // exactly the target count. A target of 0 behaves like 1.
  localparam logic [31:0] UNLOCK_LD = (UNLOCK_CYC == 32'd0) ? 32'd0 : UNLOCK_CYC - 32'd1;
  localparam logic [31:0] FAIL_LD   = (FAIL_CYC   == 32'd0) ? 32'd0 : FAIL_CYC   - 32'd1;
  localparam logic [31:0] LOCK_LD   = (LOCK_CYC   == 32'd0) ? 32'd0 : LOCK_CYC   - 32'd1;

  logic          enter_d;
  logic          enter_rise;
  logic [31:0]   timer;
  logic [31:0]   timer_nxt;
  logic [2:0]    state_nxt;
  logic          clr_nxt;
  logic [1:0]    fail_nxt;
  logic [W-1:0]  pass_reg;
  logic          timer_done;
  logic          code_full;

  assign enter_rise = enter & ~enter_d;
  assign timer_done = (timer == 32'd0);
  assign code_full  = (code_bit == FULL_BITS);

`ifdef CODE_LOCK_CHANGE_EN
  logic pass_wr;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer_done ? 32'd0 : timer - 32'd1;
    clr_nxt   = 1'b0;
    fail_nxt  = fail_cnt;
`ifdef CODE_LOCK_CHANGE_EN
    pass_wr   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // Partial codes are ignored silently; SWITCH_IO keeps collecting.
        if (enter_rise && code_full) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        clr_nxt = 1'b1;
        if (code[W-1:0] == pass_reg) begin
          state_nxt = S_OPEN;
          fail_nxt  = 2'd0;
          timer_nxt = UNLOCK_LD;
        end else if (({1'b0, fail_cnt} + 3'd1) == {1'b0, MAX_TRY_V}) begin
          // Final allowed failure: count saturates at MAX_TRY during lockout.
          state_nxt = S_LOCKOUT;
          fail_nxt  = MAX_TRY_V;
          timer_nxt = LOCK_LD;
        end else begin
          state_nxt = S_FAIL;
          fail_nxt  = fail_cnt + 2'd1;
          timer_nxt = FAIL_LD;
        end
      end
      S_OPEN: begin
        // A key press wins over a coincident timer expiry; either way one
        // return to IDLE, with a single clear pulse only for the key press.
        if (enter_rise) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
          timer_nxt = 32'd0;
`ifdef CODE_LOCK_CHANGE_EN
          pass_wr   = code_full;
`endif
        end else if (timer_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_FAIL: begin
        if (timer_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (timer_done) begin
          state_nxt = S_IDLE;
          fail_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = 32'd0;
      end
    endcase
  end

  // Indication outputs are registered from the next state so they change
  // on the same edge as `state` without decode glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= 32'd0;
      enter_d  <= 1'b0;
      clr_req  <= 1'b0;
      fail_cnt <= 2'd0;
      unlock   <= 1'b0;
      err      <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      enter_d  <= enter;
      clr_req  <= clr_nxt;
      fail_cnt <= fail_nxt;
      unlock   <= (state_nxt == S_OPEN);
      err      <= (state_nxt == S_FAIL);
      alarm    <= (state_nxt == S_LOCKOUT);
    end
  end

`ifdef CODE_LOCK_CHANGE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_reg <= PASS_INIT[W-1:0];
    end else if (pass_wr) begin
      pass_reg <= code[W-1:0];
    end
  end
`else
  assign pass_reg = PASS_INIT[W-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_code_lock_ctrl
//  Purpose  : Self-checking bench for code_lock_ctrl. A phase-counter model
//             predicts every output each cycle; directed entries exercise
//             correct/wrong/partial codes, held keys, relock, expiry races,
//             reset during lockout and (optionally) password change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enter = 1'b0;
  logic [15:0] code = 16'h0000;
  logic [2:0]  code_bit = 3'd0;
  logic        clr_req, unlock, err, alarm;
  logic [1:0]  fail_cnt;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  code_lock_ctrl #(
    .BYTE(4), .PASS_INIT(16'h1234), .MAX_TRY(3),
    .UNLOCK_CYC(32'd8), .FAIL_CYC(32'd4), .LOCK_CYC(32'd16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_bit(code_bit), .enter(enter),
    .clr_req(clr_req), .unlock(unlock), .err(err), .alarm(alarm),
    .fail_cnt(fail_cnt), .state(state)
  );

  // ---------------- behavioural model ----------------
  // Remaining visible cycles of each timed phase; the expected state is
  // whichever phase is active.
  int          open_left = 0, fail_left = 0, lock_left = 0, tries = 0;
  bit          checking = 0, m_clr = 0, prev_enter = 0;
  logic [15:0] m_pass = 16'h1234;

  task automatic model_step();
    bit rise;
    rise = enter && !prev_enter;
    prev_enter = enter;
    m_clr = 0;
    if (!rst_n) begin
      open_left = 0; fail_left = 0; lock_left = 0; tries = 0;
      checking = 0; prev_enter = 0; m_pass = 16'h1234;
    end else if (checking) begin
      checking = 0;
      m_clr = 1;
      if (code == m_pass) begin
        open_left = 8; tries = 0;
      end else if (tries + 1 >= 3) begin
        lock_left = 16; tries = 3;
      end else begin
        fail_left = 4; tries = tries + 1;
      end
    end else if (open_left > 0) begin
      if (rise) begin
        open_left = 0; m_clr = 1;
`ifdef CODE_LOCK_CHANGE_EN
        if (code_bit == 3'd4) m_pass = code;
`endif
      end else begin
        open_left = open_left - 1;
      end
    end else if (fail_left > 0) begin
      fail_left = fail_left - 1;
    end else if (lock_left > 0) begin
      lock_left = lock_left - 1;
      if (lock_left == 0) tries = 0;
    end else if (rise && code_bit == 3'd4) begin
      checking = 1;
    end
  endtask

  function automatic int exp_state();
    if (checking)       return 1;
    if (open_left > 0)  return 2;
    if (fail_left > 0)  return 3;
    if (lock_left > 0)  return 4;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  bit chk_en = 0;
  int clr_seen = 0, check_seen = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_state",    32'(state),    exp_state());
      chk("m_unlock",   32'(unlock),   (open_left > 0) ? 1 : 0);
      chk("m_err",      32'(err),      (fail_left > 0) ? 1 : 0);
      chk("m_alarm",    32'(alarm),    (lock_left > 0) ? 1 : 0);
      chk("m_fail_cnt", 32'(fail_cnt), tries);
      chk("m_clr_req",  32'(clr_req),  m_clr ? 1 : 0);
      if (clr_req === 1'b1) clr_seen++;
      if (state === 3'd1)   check_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] c, input logic [2:0] b);
    @(negedge clk);
    code = c; code_bit = b; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk_en = 1;
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", {28'd0, clr_req, unlock, err, alarm}, 0);
    chk("rst_fail_cnt", 32'(fail_cnt), 0);

    // Correct entry: CHECK, then 8 cycles OPEN, single clear pulse.
    press(16'h1234, 3'd4);
    chk("ok_check", 32'(state), 1);
    tick(1);
    chk("ok_open", 32'(state), 2);
    chk("ok_clr", 32'(clr_req), 1);
    chk("ok_unlock", 32'(unlock), 1);
    tick(1);
    chk("ok_clr_once", 32'(clr_req), 0);
    tick(6);
    chk("ok_unlock_last", 32'(unlock), 1);
    tick(1);
    chk("ok_idle", 32'(state), 0);
    chk("ok_fail_cnt", 32'(fail_cnt), 0);

    // Two wrong codes, a discarded rise during FAIL, then lockout.
    press(16'h1235, 3'd4);
    tick(1);
    chk("w1_err", 32'(err), 1);
    chk("w1_cnt", 32'(fail_cnt), 1);
    tick(4);
    chk("w1_idle", 32'(state), 0);
    press(16'h1235, 3'd4);
    tick(1);
    chk("w2_cnt", 32'(fail_cnt), 2);
    press(16'h1234, 3'd4);
    chk("w2_rise_ignored", 32'(state), 3);
    tick(2);
    chk("w2_idle", 32'(state), 0);
    press(16'h1235, 3'd4);
    tick(1);
    chk("w3_alarm", 32'(alarm), 1);
    chk("w3_cnt_sat", 32'(fail_cnt), 3);
    tick(15);
    chk("w3_alarm_last", 32'(alarm), 1);
    tick(1);
    chk("w3_idle", 32'(state), 0);
    chk("w3_cnt_clear", 32'(fail_cnt), 0);

    // Partial code leaves everything unchanged (fail_cnt held at 1).
    press(16'h1235, 3'd4);
    tick(5);
    press(16'h1234, 3'd2);
    chk("part_state", 32'(state), 0);
    tick(1);
    chk("part_clr", 32'(clr_req), 0);
    chk("part_cnt", 32'(fail_cnt), 1);
    press(16'h1234, 3'd4);
    tick(10);

    // Held key: exactly one CHECK and one clear pulse.
    tick(1);
    clr_seen = 0; check_seen = 0;
    code = 16'h1234; code_bit = 3'd4; enter = 1'b1;
    tick(20);
    enter = 1'b0;
    chk("held_clr_count", 32'(clr_seen), 1);
    chk("held_check_count", 32'(check_seen), 1);

    // Relock by a new rise while OPEN.
    tick(2);
    press(16'h1234, 3'd4);
    tick(1);
    chk("relock_open", 32'(unlock), 1);
    tick(2);
    press(16'h1234, 3'd4);
    chk("relock_state", 32'(state), 0);
    chk("relock_clr", 32'(clr_req), 1);

    // Rise coinciding with timer expiry: one return, one pulse.
    press(16'h1234, 3'd4);
    tick(7);
    press(16'h1234, 3'd4);
    chk("race_state", 32'(state), 0);
    chk("race_clr", 32'(clr_req), 1);
    tick(1);
    chk("race_clr_once", 32'(clr_req), 0);

    // Reset during LOCKOUT.
    press(16'h1235, 3'd4); tick(5);
    press(16'h1235, 3'd4); tick(5);
    press(16'h1235, 3'd4); tick(4);
    chk("rl_alarm", 32'(alarm), 1);
    rst_n = 1'b0;
    tick(1);
    chk("rl_state", 32'(state), 0);
    chk("rl_outs", {28'd0, clr_req, unlock, err, alarm}, 0);
    chk("rl_cnt", 32'(fail_cnt), 0);
    rst_n = 1'b1;
    press(16'h1234, 3'd4);
    tick(1);
    chk("rl_reopen", 32'(unlock), 1);
    tick(10);

`ifdef CODE_LOCK_CHANGE_EN
    press(16'h1234, 3'd4);
    tick(2);
    press(16'h5678, 3'd4);
    chk("chg_state", 32'(state), 0);
    chk("chg_clr", 32'(clr_req), 1);
    press(16'h1234, 3'd4);
    tick(1);
    chk("chg_old_fails", 32'(err), 1);
    tick(5);
    press(16'h5678, 3'd4);
    tick(1);
    chk("chg_new_opens", 32'(unlock), 1);
    tick(10);
`else
    press(16'h1234, 3'd4);
    tick(2);
    press(16'h5678, 3'd4);
    chk("fix_relock", 32'(state), 0);
    press(16'h5678, 3'd4);
    tick(1);
    chk("fix_new_fails", 32'(err), 1);
    tick(5);
    press(16'h1234, 3'd4);
    tick(1);
    chk("fix_old_opens", 32'(unlock), 1);
    tick(10);
`endif

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
